ov_7670_capture: RTL and testbench

- Downstream neighbour of the OV7670 init controller.
- Once init reports done, it captures the camera's parallel RGB565 stream (VSYNC/HREF/D[7:0]) and assembles byte pairs into 16-bit pixels.
- Each pixel goes out with a linear frame-buffer write address and x/y coordinates, plus frame start/done strobes and sticky line/frame geometry error flags.

---
 rtl/ov_7670_capture_pkg.sv | 14 +
 rtl/ov_7670_capture_if.sv | 29 ++
 rtl/ov_7670_capture_byte_pair.sv | 33 +++
 rtl/ov_7670_capture.sv | 175 +++++++++++++++++
 tb/tb_ov_7670_capture.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ov_7670_capture_pkg.sv
// Shared types and default geometry for the OV7670 capture path.
// States and the 640x480 defaults live here so sub-blocks agree.
package ov_cam_pkg;

  typedef enum logic [1:0] {
    S_WAIT_INIT,
    S_WAIT_FRAME,
    S_ACTIVE
  } state_t;

  localparam int H_DEF = 640;
  localparam int V_DEF = 480;

endpackage

// File: rtl/ov_7670_capture_if.sv
// Pixel write bus from the capture block into a frame buffer.
// master drives a pixel strobe with its address and coordinates.
interface ov_7670_capture_if #(
  parameter int ADDR_W = 19
);

  logic [15:0]       pix_data;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [9:0]        pix_x;
  logic [8:0]        pix_y;

  modport master (
    output pix_data,
    output pix_valid,
    output pix_addr,
    output pix_x,
    output pix_y
  );

  modport slave (
    input pix_data,
    input pix_valid,
    input pix_addr,
    input pix_x,
    input pix_y
  );

endinterface

// File: rtl/ov_7670_capture_byte_pair.sv
// Pairs camera bytes into RGB565 words: first byte high, second low.
// The strobe is combinational on the second byte; the top registers it.
module ov_byte_pair (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_d,
  output logic [15:0] o_pix,
  output logic        o_stb,
  output logic        o_phase
);

  logic       r_phase;
  logic [7:0] r_hi;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase <= 1'b0;
      r_hi    <= '0;
    end else if (i_clr) begin
      r_phase <= 1'b0;
    end else if (i_en) begin
      r_phase <= ~r_phase;
      if (!r_phase) r_hi <= i_d;
    end
  end

  assign o_pix   = {r_hi, i_d};
  assign o_stb   = i_en & r_phase & ~i_clr;
  assign o_phase = r_phase;

endmodule

// File: rtl/ov_7670_capture.sv
// OV7670 RGB565 capture: frames gated by init/enable, pixels to a
// linear frame buffer with sticky line/frame geometry error flags.
module ov_7670_capture
  import ov_cam_pkg::*;
#(
  parameter int H_PIXELS = H_DEF,
  parameter int V_LINES  = V_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init_done,
  input  logic               enable,
  input  logic               cam_vsync,
  input  logic               cam_href,
  input  logic [7:0]         cam_d,
  ov_7670_capture_if.master  pix,
  output logic               frame_start,
  output logic               frame_done,
  output logic               line_err,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [9:0]        LP_H  = 10'(H_PIXELS);
  localparam logic [8:0]        LP_V  = 9'(V_LINES);
  localparam logic [ADDR_W-1:0] LP_HA = ADDR_W'(H_PIXELS);

  state_t r_state, w_next;

  logic              r_vs, r_vs_d, r_hs, r_href_q;
  logic [7:0]        r_d;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic [ADDR_W-1:0] r_addr, r_base;
  logic [15:0]       r_pd;
  logic              r_pv;
  logic [ADDR_W-1:0] r_pa;
  logic [9:0]        r_px;
  logic [8:0]        r_py;

  logic        w_href, w_href_fall, w_vs_fall, w_vs_rise;
  logic        w_start, w_done, w_active;
  logic        w_line_end, w_en, w_clr, w_wr;
  logic        w_stb, w_phase;
  logic [15:0] w_pix;
  logic [8:0]  w_y_nx;

  // href is only meaningful outside vertical blanking
  assign w_href      = r_hs & ~r_vs;
  assign w_href_fall = r_href_q & ~w_href;
  assign w_vs_fall   = r_vs_d & ~r_vs;
  assign w_vs_rise   = r_vs & ~r_vs_d;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_WAIT_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_done   = 1'b0;
    w_active = 1'b0;
    unique case (r_state)
      S_WAIT_INIT: begin
        if (init_done) w_next = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (!init_done) begin
          w_next = S_WAIT_INIT;
        end else if (w_vs_fall && enable) begin
          w_next  = S_ACTIVE;
          w_start = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!init_done) begin
          w_next = S_WAIT_INIT;
        end else begin
          w_active = 1'b1;
          if (w_vs_rise) begin
            w_next = S_WAIT_FRAME;
            w_done = 1'b1;
          end
        end
      end
      default: w_next = S_WAIT_INIT;
    endcase
  end

  assign w_line_end = w_active & w_href_fall;
  assign w_en       = w_active & w_href;
  assign w_clr      = w_start | w_line_end;
  assign w_wr       = w_stb & (r_x < LP_H) & (r_y < LP_V);
  assign w_y_nx     = (w_line_end && r_y != '1) ? r_y + 9'd1 : r_y;

  ov_byte_pair u_pair (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_d     (r_d),
    .o_pix   (w_pix),
    .o_stb   (w_stb),
    .o_phase (w_phase)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vs        <= 1'b0;
      r_vs_d      <= 1'b0;
      r_hs        <= 1'b0;
      r_href_q    <= 1'b0;
      r_d         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_addr      <= '0;
      r_base      <= '0;
      r_pd        <= '0;
      r_pv        <= 1'b0;
      r_pa        <= '0;
      r_px        <= '0;
      r_py        <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      r_vs        <= cam_vsync;
      r_vs_d      <= r_vs;
      r_hs        <= cam_href;
      r_d         <= cam_d;
      r_href_q    <= w_href;
      r_pv        <= w_wr;
      frame_start <= w_start;
      frame_done  <= w_done;
      if (w_wr) begin
        r_pd   <= w_pix;
        r_pa   <= r_addr;
        r_px   <= r_x;
        r_py   <= r_y;
        r_addr <= r_addr + 1'b1;
      end
      if (w_stb && r_x != '1) r_x <= r_x + 10'd1;
      if (w_line_end) begin
        if (w_phase || r_x != LP_H) line_err <= 1'b1;
        r_x <= '0;
        r_y <= w_y_nx;
        // row base stops once past the last line so it cannot wrap
        if (r_y < LP_V) begin
          r_base <= r_base + LP_HA;
          r_addr <= r_base + LP_HA;
        end else begin
          r_addr <= r_base;
        end
      end
      if (w_done && w_y_nx != LP_V) frame_err <= 1'b1;
      if (w_start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
        r_base <= '0;
      end
    end
  end

  assign pix.pix_data  = r_pd;
  assign pix.pix_valid = r_pv;
  assign pix.pix_addr  = r_pa;
  assign pix.pix_x     = r_px;
  assign pix.pix_y     = r_py;
  assign busy          = (r_state == S_ACTIVE);

endmodule

// File: tb/tb_ov_7670_capture.sv
// Directed bench for ov_7670_capture in a 4x2 geometry.
// Bytes follow b(k)=0x12+0x22*k (mod 256), k restarting each frame.
module tb_ov_7670_capture;

  logic       clk = 1'b0;
  logic       reset_n, init_done, enable;
  logic       cam_vsync, cam_href;
  logic [7:0] cam_d;
  logic       frame_start, frame_done, line_err, frame_err, busy;

  ov_7670_capture_if #(.ADDR_W(3)) pif ();

  ov_7670_capture #(
    .H_PIXELS (4),
    .V_LINES  (2),
    .ADDR_W   (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .init_done   (init_done),
    .enable      (enable),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_d       (cam_d),
    .pix         (pif),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int g_k   = 0;
  int n_fs  = 0;
  int n_fd  = 0;
  logic fe_at_done = 1'b0;
  logic [2:0]  q_addr[$];
  logic [15:0] q_data[$];
  logic [9:0]  q_x[$];
  logic [8:0]  q_y[$];

  always @(negedge clk) begin
    if (pif.pix_valid) begin
      q_addr.push_back(pif.pix_addr);
      q_data.push_back(pif.pix_data);
      q_x.push_back(pif.pix_x);
      q_y.push_back(pif.pix_y);
    end
    if (frame_start) n_fs++;
    if (frame_done) begin
      n_fd++;
      fe_at_done = frame_err;
    end
  end

  function automatic logic [7:0] bval(input int k);
    logic [7:0] kk;
    kk = 8'(k);
    return 8'h12 + 8'h22 * kk;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_log();
    q_addr.delete();
    q_data.delete();
    q_x.delete();
    q_y.delete();
    n_fs = 0;
    n_fd = 0;
    fe_at_done = 1'b0;
  endtask

  task automatic vs_low();
    @(negedge clk);
    cam_vsync = 1'b0;
  endtask

  task automatic vs_high();
    @(negedge clk);
    cam_vsync = 1'b1;
    idle(4);
  endtask

  task automatic line(input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_d    = bval(g_k);
      g_k++;
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_d    = 8'h00;
    idle(4);
  endtask

  task automatic frame2(input int nb0, input int nb1);
    g_k = 0;
    vs_low();
    idle(4);
    line(nb0);
    if (nb1 > 0) line(nb1);
    vs_high();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_reset();
    idle(3);
    n_chk++;
    if ({pif.pix_valid, frame_start, frame_done, line_err, frame_err, busy} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {pif.pix_valid, frame_start, frame_done, line_err, frame_err, busy});
    end
    n_chk++;
    if ({pif.pix_data, pif.pix_addr, pif.pix_x, pif.pix_y} !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h want 0",
               {pif.pix_data, pif.pix_addr, pif.pix_x, pif.pix_y});
    end
    reset_n = 1'b1;
    idle(2);
    n_chk++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_init_gate();
    clr_log();
    frame2(8, 8);
    n_chk++;
    if (q_addr.size() != 0 || n_fs != 0) begin
      n_bad++;
      $display("FAIL noinit_quiet: got pix=%0d fs=%0d want 0 0", q_addr.size(), n_fs);
    end
    init_done = 1'b1;
    idle(4);
    clr_log();
    g_k = 0;
    vs_low();
    @(posedge clk);
    #1;
    n_chk++;
    if (frame_start !== 1'b0) begin
      n_bad++;
      $display("FAIL fs_early: got %b want 0", frame_start);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (frame_start !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fs_timing: got fs=%b busy=%b want 1 1", frame_start, busy);
    end
    idle(4);
    line(8);
    line(8);
    vs_high();
    n_chk++;
    if (n_fs != 1 || n_fd != 1 || q_addr.size() != 8) begin
      n_bad++;
      $display("FAIL init_frame: got fs=%0d fd=%0d pix=%0d want 1 1 8",
               n_fs, n_fd, q_addr.size());
    end
  endtask

  task automatic test_frame_4x2();
    logic [15:0] d0;
    logic [2:0]  al;
    clr_log();
    frame2(8, 8);
    n_chk++;
    if (q_addr.size() != 8) begin
      n_bad++;
      $display("FAIL f42_count: got %0d want 8", q_addr.size());
    end
    d0 = (q_data.size() > 0) ? q_data[0] : 16'hxxxx;
    al = (q_addr.size() > 0) ? q_addr[q_addr.size()-1] : 3'bxxx;
    n_chk++;
    if (d0 !== 16'h1234) begin
      n_bad++;
      $display("FAIL f42_first: got %h want 1234", d0);
    end
    n_chk++;
    if (al !== 3'd7) begin
      n_bad++;
      $display("FAIL f42_last_addr: got %0d want 7", al);
    end
    for (int i = 0; i < q_addr.size() && i < 8; i++) begin
      n_chk++;
      if (q_addr[i] !== 3'(i) || q_data[i] !== {bval(2*i), bval(2*i+1)} ||
          q_x[i] !== 10'(i % 4) || q_y[i] !== 9'(i / 4)) begin
        n_bad++;
        $display("FAIL f42_pix%0d: got a=%0d d=%h x=%0d y=%0d want a=%0d d=%h x=%0d y=%0d",
                 i, q_addr[i], q_data[i], q_x[i], q_y[i],
                 i, {bval(2*i), bval(2*i+1)}, i % 4, i / 4);
      end
    end
    n_chk++;
    if (n_fd != 1 || line_err !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL f42_done: got fd=%0d le=%b fe=%b want 1 0 0", n_fd, line_err, frame_err);
    end
  endtask

  task automatic test_enable();
    clr_log();
    enable = 1'b0;
    frame2(8, 8);
    n_chk++;
    if (n_fs != 0 || q_addr.size() != 0) begin
      n_bad++;
      $display("FAIL en_skip: got fs=%0d pix=%0d want 0 0", n_fs, q_addr.size());
    end
    enable = 1'b1;
    clr_log();
    g_k = 0;
    vs_low();
    idle(4);
    line(8);
    enable = 1'b0;
    line(8);
    vs_high();
    n_chk++;
    if (n_fd != 1 || q_addr.size() != 8) begin
      n_bad++;
      $display("FAIL en_drop: got fd=%0d pix=%0d want 1 8", n_fd, q_addr.size());
    end
    clr_log();
    frame2(8, 8);
    n_chk++;
    if (n_fs != 0 || n_fd != 0 || q_addr.size() != 0) begin
      n_bad++;
      $display("FAIL en_after: got fs=%0d fd=%0d pix=%0d want 0 0 0",
               n_fs, n_fd, q_addr.size());
    end
    enable = 1'b1;
  endtask

  task automatic test_odd_line();
    logic [2:0]  a3;
    logic [15:0] d3;
    clr_log();
    frame2(7, 8);
    n_chk++;
    if (q_addr.size() != 7) begin
      n_bad++;
      $display("FAIL odd_count: got %0d want 7", q_addr.size());
    end
    a3 = (q_addr.size() > 3) ? q_addr[3] : 3'bxxx;
    d3 = (q_data.size() > 3) ? q_data[3] : 16'hxxxx;
    n_chk++;
    if (a3 !== 3'd4 || d3 !== 16'h0022) begin
      n_bad++;
      $display("FAIL odd_next_line: got a=%0d d=%h want a=4 d=0022", a3, d3);
    end
    n_chk++;
    if (line_err !== 1'b1 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL odd_flags: got le=%b fe=%b want 1 0", line_err, frame_err);
    end
    do_reset();
    n_chk++;
    if (line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL odd_clear: got %b want 0", line_err);
    end
  endtask

  task automatic test_short_frame();
    clr_log();
    frame2(8, 0);
    n_chk++;
    if (n_fd != 1 || fe_at_done !== 1'b1 || line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL short_frame: got fd=%0d fe=%b le=%b want 1 1 0",
               n_fd, fe_at_done, line_err);
    end
    n_chk++;
    if (q_addr.size() != 4) begin
      n_bad++;
      $display("FAIL short_count: got %0d want 4", q_addr.size());
    end
    do_reset();
  endtask

  task automatic test_long_line();
    logic [2:0] a4, al;
    clr_log();
    frame2(12, 8);
    a4 = (q_addr.size() > 4) ? q_addr[4] : 3'bxxx;
    al = (q_addr.size() > 0) ? q_addr[q_addr.size()-1] : 3'bxxx;
    n_chk++;
    if (q_addr.size() != 8 || a4 !== 3'd4 || al !== 3'd7) begin
      n_bad++;
      $display("FAIL long_pix: got n=%0d a4=%0d last=%0d want 8 4 7",
               q_addr.size(), a4, al);
    end
    n_chk++;
    if (line_err !== 1'b1 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL long_flags: got le=%b fe=%b want 1 0", line_err, frame_err);
    end
    do_reset();
  endtask

  task automatic test_reset_midline();
    clr_log();
    g_k = 0;
    vs_low();
    idle(4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_d    = bval(g_k);
      g_k++;
    end
    n_chk++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_busy: got %b want 1", busy);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({pif.pix_valid, pif.pix_data, pif.pix_addr, pif.pix_x, pif.pix_y,
         frame_start, frame_done, line_err, frame_err, busy} !== 44'h0) begin
      n_bad++;
      $display("FAIL rst_mid: got %h want 0",
               {pif.pix_valid, pif.pix_data, pif.pix_addr, pif.pix_x, pif.pix_y,
                frame_start, frame_done, line_err, frame_err, busy});
    end
    @(negedge clk);
    reset_n = 1'b1;
    clr_log();
    line(3);
    line(8);
    vs_high();
    n_chk++;
    if (n_fs != 0 || n_fd != 0 || q_addr.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_abandon: got fs=%0d fd=%0d pix=%0d busy=%b want 0 0 0 0",
               n_fs, n_fd, q_addr.size(), busy);
    end
    clr_log();
    frame2(8, 8);
    n_chk++;
    if (n_fs != 1 || n_fd != 1 || q_addr.size() != 8) begin
      n_bad++;
      $display("FAIL rst_fresh: got fs=%0d fd=%0d pix=%0d want 1 1 8",
               n_fs, n_fd, q_addr.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    init_done = 1'b0;
    enable    = 1'b1;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_d     = 8'h00;
    test_reset();
    test_init_gate();
    test_frame_4x2();
    test_enable();
    test_odd_line();
    test_short_frame();
    test_long_line();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
